// File: rtl/accumulator_stack.sv
// Synchronous accumulator with ALU-style update ops, status flags and a
// DEPTH-entry LIFO save/restore stack behind the working register.
module accumulator_stack #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             write_bit,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] write_port,
    input  logic             push,
    input  logic             pop,
    output logic [WIDTH-1:0] read_port,
    output logic             carry,
    output logic             overflow,
    output logic             zero,
    output logic             negative,
    output logic             stack_full,
    output logic             stack_empty,
    output logic             stack_err
);

    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned MSB   = WIDTH - 1;

    localparam logic [2:0] OP_HOLD = 3'b000;
    localparam logic [2:0] OP_LOAD = 3'b001;
    localparam logic [2:0] OP_ADD  = 3'b010;
    localparam logic [2:0] OP_SUB  = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_OR   = 3'b101;
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_SHL  = 3'b111;

    logic [WIDTH-1:0] acc_q, acc_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             err_q, err_d;
    logic [WIDTH-1:0] stack_q [DEPTH];
    logic [WIDTH-1:0] stack_d [DEPTH];

    logic [WIDTH:0]   sum;
    logic [WIDTH:0]   diff;
    logic [CNT_W-1:0] count_m1;
    logic [IDX_W-1:0] push_idx;
    logic [IDX_W-1:0] pop_idx;
    logic             full;
    logic             empty;
    logic             push_ok;
    logic             pop_ok;

    assign full     = (count_q == CNT_W'(DEPTH));
    assign empty    = (count_q == '0);
    assign push_ok  = push && !pop && !full;
    assign pop_ok   = pop && !push && !empty;
    assign count_m1 = count_q - 1'b1;
    assign push_idx = count_q[IDX_W-1:0];
    assign pop_idx  = count_m1[IDX_W-1:0];
    assign sum      = {1'b0, acc_q} + {1'b0, write_port};
    assign diff     = {1'b0, acc_q} - {1'b0, write_port};

    always_comb begin
        acc_d   = acc_q;
        carry_d = carry_q;
        ovf_d   = ovf_q;
        count_d = count_q;
        stack_d = stack_q;
        err_d   = (push && pop) || (push && !pop && full) || (pop && !push && empty);

        if (write_bit) begin
            case (op)
                OP_HOLD: ;
                OP_LOAD: begin
                    acc_d   = write_port;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_ADD: begin
                    acc_d   = sum[WIDTH-1:0];
                    carry_d = sum[WIDTH];
                    ovf_d   = (acc_q[MSB] == write_port[MSB]) && (sum[MSB] != acc_q[MSB]);
                end
                OP_SUB: begin
                    acc_d   = diff[WIDTH-1:0];
                    carry_d = diff[WIDTH];
                    ovf_d   = (acc_q[MSB] != write_port[MSB]) && (diff[MSB] != acc_q[MSB]);
                end
                OP_AND: begin
                    acc_d   = acc_q & write_port;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_OR: begin
                    acc_d   = acc_q | write_port;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_XOR: begin
                    acc_d   = acc_q ^ write_port;
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                end
                OP_SHL: begin
                    acc_d   = {acc_q[WIDTH-2:0], 1'b0};
                    carry_d = acc_q[MSB];
                    ovf_d   = acc_q[MSB] ^ acc_q[MSB-1];
                end
                default: ;
            endcase
        end

        // Push saves the pre-op value; a legal pop overrides any op result.
        if (push_ok) begin
            stack_d[push_idx] = acc_q;
            count_d           = count_q + 1'b1;
        end
        if (pop_ok) begin
            acc_d   = stack_q[pop_idx];
            carry_d = 1'b0;
            ovf_d   = 1'b0;
            count_d = count_m1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            acc_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            acc_q   <= acc_d;
            carry_q <= carry_d;
            ovf_q   <= ovf_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        stack_q <= stack_d;
    end

    assign read_port   = acc_q;
    assign carry       = carry_q;
    assign overflow    = ovf_q;
    assign zero        = (acc_q == '0);
    assign negative    = acc_q[MSB];
    assign stack_full  = full;
    assign stack_empty = empty;
    assign stack_err   = err_q;

endmodule

// File: tb/tb_accumulator_stack.sv
// Directed bench for accumulator_stack: hand-computed vectors for ops,
// flags, stack fill/drain and the illegal-request corners.
module tb_accumulator_stack;

    logic       clk;
    logic       reset;
    logic       write_bit;
    logic [2:0] op;
    logic [7:0] write_port;
    logic       push;
    logic       pop;
    logic [7:0] read_port;
    logic       carry;
    logic       overflow;
    logic       zero;
    logic       negative;
    logic       stack_full;
    logic       stack_empty;
    logic       stack_err;

    int unsigned errors = 0;
    int unsigned checks = 0;

    accumulator_stack #(.WIDTH(8), .DEPTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .write_bit  (write_bit),
        .op         (op),
        .write_port (write_port),
        .push       (push),
        .pop        (pop),
        .read_port  (read_port),
        .carry      (carry),
        .overflow   (overflow),
        .zero       (zero),
        .negative   (negative),
        .stack_full (stack_full),
        .stack_empty(stack_empty),
        .stack_err  (stack_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Drive inputs for one cycle, then sample 1 time unit after the edge.
    task automatic cyc(input logic wb, input logic [2:0] o, input logic [7:0] wp,
                       input logic pu, input logic po);
        write_bit  = wb;
        op         = o;
        write_port = wp;
        push       = pu;
        pop        = po;
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset = 1'b1;
        cyc(1'b1, 3'b001, 8'h5A, 1'b1, 1'b0);
        cyc(1'b1, 3'b010, 8'hC3, 1'b0, 1'b1);
        reset = 1'b0;
        check("rst_acc",   16'(read_port),   16'h00);
        check("rst_zero",  16'(zero),        16'h1);
        check("rst_carry", 16'(carry),       16'h0);
        check("rst_ovf",   16'(overflow),    16'h0);
        check("rst_empty", 16'(stack_empty), 16'h1);
        check("rst_full",  16'(stack_full),  16'h0);
        check("rst_err",   16'(stack_err),   16'h0);

        cyc(1'b1, 3'b001, 8'h7F, 1'b0, 1'b0);
        check("load7f", 16'(read_port), 16'h7F);
        cyc(1'b1, 3'b010, 8'h01, 1'b0, 1'b0);
        check("add1_acc", 16'(read_port), 16'h80);
        check("add1_c",   16'(carry),     16'h0);
        check("add1_v",   16'(overflow),  16'h1);
        check("add1_n",   16'(negative),  16'h1);
        cyc(1'b1, 3'b010, 8'h80, 1'b0, 1'b0);
        check("add2_acc", 16'(read_port), 16'h00);
        check("add2_c",   16'(carry),     16'h1);
        check("add2_v",   16'(overflow),  16'h1);
        check("add2_z",   16'(zero),      16'h1);

        cyc(1'b1, 3'b001, 8'h05, 1'b0, 1'b0);
        check("load_clr_c", 16'(carry), 16'h0);
        cyc(1'b1, 3'b011, 8'h07, 1'b0, 1'b0);
        check("sub_acc", 16'(read_port), 16'hFE);
        check("sub_c",   16'(carry),     16'h1);
        check("sub_v",   16'(overflow),  16'h0);
        check("sub_n",   16'(negative),  16'h1);
        cyc(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        check("shl_acc", 16'(read_port), 16'hFC);
        check("shl_c",   16'(carry),     16'h1);
        check("shl_v",   16'(overflow),  16'h0);
        cyc(1'b0, 3'b010, 8'h33, 1'b0, 1'b0);
        check("hold_acc", 16'(read_port), 16'hFC);
        check("hold_c",   16'(carry),     16'h1);
        cyc(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        check("shl2_acc", 16'(read_port), 16'hF8);
        cyc(1'b1, 3'b001, 8'h40, 1'b0, 1'b0);
        cyc(1'b1, 3'b111, 8'h00, 1'b0, 1'b0);
        check("shl3_acc", 16'(read_port), 16'h80);
        check("shl3_c",   16'(carry),     16'h0);
        check("shl3_v",   16'(overflow),  16'h1);

        cyc(1'b1, 3'b001, 8'hF0, 1'b0, 1'b0);
        cyc(1'b1, 3'b100, 8'h3C, 1'b0, 1'b0);
        check("and", 16'(read_port), 16'h30);
        cyc(1'b1, 3'b101, 8'h0F, 1'b0, 1'b0);
        check("or", 16'(read_port), 16'h3F);
        cyc(1'b1, 3'b110, 8'hFF, 1'b0, 1'b0);
        check("xor", 16'(read_port), 16'hC0);
        cyc(1'b1, 3'b000, 8'hFF, 1'b0, 1'b0);
        check("op_hold", 16'(read_port), 16'hC0);

        cyc(1'b1, 3'b001, 8'h11, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            cyc(1'b1, 3'b010, 8'h01, 1'b1, 1'b0);
            check("fill_err", 16'(stack_err), 16'h0);
        end
        check("fill_acc",  16'(read_port),  16'h15);
        check("fill_full", 16'(stack_full), 16'h1);
        cyc(1'b0, 3'b000, 8'h00, 1'b1, 1'b0);
        check("ovpush_err",  16'(stack_err),  16'h1);
        check("ovpush_full", 16'(stack_full), 16'h1);
        check("ovpush_acc",  16'(read_port),  16'h15);
        cyc(1'b1, 3'b011, 8'h20, 1'b0, 1'b0);
        check("err_pulse", 16'(stack_err), 16'h0);
        check("presub_acc", 16'(read_port), 16'hF5);
        check("presub_c",   16'(carry),     16'h1);

        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("pop1_acc", 16'(read_port),  16'h14);
        check("pop1_c",   16'(carry),      16'h0);
        check("pop1_full", 16'(stack_full), 16'h0);
        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("pop2_acc", 16'(read_port), 16'h13);
        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("pop3_acc", 16'(read_port), 16'h12);
        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("pop4_acc",   16'(read_port),   16'h11);
        check("pop4_empty", 16'(stack_empty), 16'h1);
        check("pop4_err",   16'(stack_err),   16'h0);
        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("unpop_err", 16'(stack_err), 16'h1);
        check("unpop_acc", 16'(read_port), 16'h11);

        cyc(1'b0, 3'b000, 8'h00, 1'b1, 1'b0);
        check("push1_err",   16'(stack_err),   16'h0);
        check("push1_empty", 16'(stack_empty), 16'h0);
        cyc(1'b1, 3'b001, 8'hAA, 1'b0, 1'b1);
        check("popwin_acc", 16'(read_port),   16'h11);
        check("popwin_err", 16'(stack_err),   16'h0);
        check("popwin_mt",  16'(stack_empty), 16'h1);
        cyc(1'b1, 3'b001, 8'h33, 1'b1, 1'b1);
        check("pp_err",   16'(stack_err),   16'h1);
        check("pp_empty", 16'(stack_empty), 16'h1);
        check("pp_acc",   16'(read_port),   16'h33);
        cyc(1'b1, 3'b010, 8'h01, 1'b0, 1'b1);
        check("unpop_op_acc", 16'(read_port), 16'h34);
        check("unpop_op_err", 16'(stack_err), 16'h1);

        cyc(1'b0, 3'b000, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 3'b000, 8'h00, 1'b1, 1'b0);
        check("mid_empty", 16'(stack_empty), 16'h0);
        reset = 1'b1;
        cyc(1'b1, 3'b001, 8'h77, 1'b1, 1'b0);
        reset = 1'b0;
        check("mid_rst_acc",   16'(read_port),   16'h00);
        check("mid_rst_empty", 16'(stack_empty), 16'h1);
        check("mid_rst_err",   16'(stack_err),   16'h0);
        cyc(1'b0, 3'b000, 8'h00, 1'b0, 1'b1);
        check("post_rst_pop_err", 16'(stack_err), 16'h1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
